ising_run_ctrl: RTL and testbench
=================================

ISING_RUN_CTRL -- requirements
Module: ising_run_ctrl

Interface
REQ-001: Parameter N, default 3: number of spins; width of core_phase and result.
REQ-002: Parameter SETTLE_CYCLES, default 4: cycles core_rstn is held low after start, before the run; legal range 1..255.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: rstn  input  1  reset, asynchronous and active-low.
REQ-005: w_valid / w_ready  input / output  1 / 1  weight-write handshake; a write transfers when both are high on a rising edge.
REQ-006: w_addr / w_data  input  32 / 32  weight address and data; sampled on transfer.
REQ-007: start_valid / start_ready  input / output  1 / 1  run-request handshake; transfers when both are high.
REQ-008: run_cycles  input  32  run length in clk cycles; latched on start transfer.
REQ-009: abort  input  1  level; terminates a run in progress.
REQ-010: core_rstn  output  1  oscillator-array and sampler reset, active-low.
REQ-011: core_axi_rstn  output  1  weight-memory reset, active-low.
REQ-012: core_wready / core_wr_addr / core_wdata  output  1 / 32 / 32  weight write strobe, address and data to the core.
REQ-013: core_phase  input  N  sampler phase output.
REQ-014: result  output  N  last captured phase.
REQ-015: done  output  1  one-cycle pulse when result updates.
REQ-016: busy  output  1  high in SETTLE, RUN and CAPTURE.

Function
REQ-017: States are IDLE, SETTLE, RUN, CAPTURE and DONE; the state register is binary-encoded.
REQ-018: IDLE: core_rstn=0; writes are accepted; start_ready = no write pending and w_valid low.
REQ-019: Each accepted write drives core_wready high for exactly one cycle, the cycle after transfer, with the registered addr/data.
- core_wr_addr/core_wdata hold their last values otherwise.
REQ-020: w_valid and start_valid high together in IDLE: the write transfers and the start does not.
REQ-021: On start transfer: run_cycles is latched (0 treated as 1); next state SETTLE.
REQ-022: SETTLE: core_rstn=0 for exactly SETTLE_CYCLES cycles; then RUN.
REQ-023: RUN: core_rstn=1 for exactly the latched count of cycles, counted by a 32-bit down-counter; then CAPTURE.
REQ-024: CAPTURE (1 cycle): core_rstn=1; result <= core_phase at the end of the cycle; next state DONE.
REQ-025: DONE (1 cycle): done=1, core_rstn=0; next state IDLE.
REQ-026: abort high in SETTLE or RUN: next state IDLE, core_rstn=0 from the next cycle, no done pulse, result unchanged.
REQ-027: abort is ignored in IDLE, CAPTURE and DONE.
REQ-028: core_axi_rstn=1 in every state after reset release.
REQ-029: Without the FIFO, w_ready is low outside IDLE.
REQ-030: Start-to-done latency = 1 + SETTLE_CYCLES + run_cycles + 1 cycles; done is asserted in the cycle after that.

Reset
REQ-031: While rstn is low, all outputs are zero: core_rstn, core_axi_rstn, core_wready, core_wr_addr, core_wdata, result, done, busy, w_ready and start_ready.
- State = IDLE; counters = 0; FIFO empty.
REQ-032: Reset asserted mid-run or mid-write aborts immediately; any pending write is discarded.
REQ-033: core_axi_rstn rises on the first clk edge after rstn deasserts.

Configuration
REQ-034: Macro ISING_CTRL_WFIFO_EN defined: a 4-entry write FIFO is instantiated.
- w_ready = FIFO not full, in every state.
- The FIFO drains one entry per cycle to the core only in IDLE.
- start_ready additionally requires the FIFO to be empty.
REQ-035: ISING_CTRL_WFIFO_EN undefined: a single holding register replaces the FIFO; REQ-029 applies.

Verification
REQ-036: Reset, then write (addr 0x10, data 0x5) -> core_wready pulses 1 cycle with 0x10/0x5; start_ready low that cycle.
REQ-037: start with run_cycles=8, SETTLE_CYCLES=4 -> core_rstn high 8 cycles; done pulses 14 cycles after start; result = core_phase at the CAPTURE cycle.
REQ-038: run_cycles=0 -> behaves as 1; core_rstn high exactly 1 cycle.
REQ-039: abort on the 3rd RUN cycle -> IDLE next cycle, no done, result keeps its prior value.
REQ-040: w_valid and start_valid together in IDLE -> the write is accepted and the start is held off until the write has drained.
REQ-041: With ISING_CTRL_WFIFO_EN, 5 back-to-back writes during RUN -> 4 accepted, w_ready low on the 5th; all 4 drain in order after DONE.

Source files
------------

// File: rtl/ising_run_ctrl.sv
// Run controller for an Ising oscillator core: weight loading, settle, timed run, phase capture.
// Define ISING_CTRL_WFIFO_EN to buffer weight writes in a 4-entry FIFO instead of one holding register.
module ising_run_ctrl #(
    parameter int N             = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [31:0]  w_addr,
    input  logic [31:0]  w_data,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [31:0]  run_cycles,
    input  logic         abort,
    output logic         core_rstn,
    output logic         core_axi_rstn,
    output logic         core_wready,
    output logic [31:0]  core_wr_addr,
    output logic [31:0]  core_wdata,
    input  logic [N-1:0] core_phase,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

    state_t       r_state;
    state_t       w_next_state;
    logic [31:0]  r_cnt;
    logic [31:0]  r_run_len;
    logic         r_axi_rstn;
    logic         r_core_wready;
    logic [31:0]  r_core_wr_addr;
    logic [31:0]  r_core_wdata;
    logic [N-1:0] r_result;
    logic         w_is_idle;
    logic         w_wr_xfer;
    logic         w_start_xfer;
    logic         w_core_load;
    logic [31:0]  w_load_addr;
    logic [31:0]  w_load_data;
    logic         w_core_rstn;
    logic         w_busy;
    logic         w_done;

    assign w_is_idle    = (r_state == S_IDLE);
    assign w_wr_xfer    = w_valid && w_ready;
    assign w_start_xfer = start_valid && start_ready;

`ifdef ISING_CTRL_WFIFO_EN
    logic [31:0] r_fifo_addr [4];
    logic [31:0] r_fifo_data [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_bypass;

    assign w_full      = (r_count == 3'd4);
    assign w_empty     = (r_count == 3'd0);
    assign w_ready     = r_axi_rstn && !w_full;
    // An idle controller with an empty FIFO forwards the write directly to keep one-cycle latency
    assign w_bypass    = w_wr_xfer && w_is_idle && w_empty;
    assign w_push      = w_wr_xfer && !w_bypass;
    assign w_pop       = w_is_idle && !w_empty;
    assign start_ready = r_axi_rstn && w_is_idle && w_empty && !r_core_wready && !w_valid;
    assign w_core_load = w_pop || w_bypass;
    assign w_load_addr = w_pop ? r_fifo_addr[r_rd_ptr] : w_addr;
    assign w_load_data = w_pop ? r_fifo_data[r_rd_ptr] : w_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_addr;
            r_fifo_data[r_wr_ptr] <= w_data;
        end
    end
`else
    assign w_ready     = r_axi_rstn && w_is_idle;
    assign start_ready = r_axi_rstn && w_is_idle && !r_core_wready && !w_valid;
    assign w_core_load = w_wr_xfer;
    assign w_load_addr = w_addr;
    assign w_load_data = w_data;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_core_wready  <= 1'b0;
            r_core_wr_addr <= 32'd0;
            r_core_wdata   <= 32'd0;
        end else begin
            r_core_wready <= w_core_load;
            if (w_core_load) begin
                r_core_wr_addr <= w_load_addr;
                r_core_wdata   <= w_load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_axi_rstn <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_axi_rstn <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_core_rstn  = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_xfer) w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                w_busy = 1'b1;
                if (abort)              w_next_state = S_IDLE;
                else if (r_cnt == 32'd0) w_next_state = S_RUN;
            end
            S_RUN: begin
                w_busy      = 1'b1;
                w_core_rstn = 1'b1;
                if (abort)              w_next_state = S_IDLE;
                else if (r_cnt == 32'd0) w_next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_busy       = 1'b1;
                w_core_rstn  = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // One down-counter serves both the settle and run windows; it is reloaded on the settle-to-run hop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= 32'd0;
            r_run_len <= 32'd0;
        end else if (w_start_xfer) begin
            r_cnt     <= SETTLE_LOAD;
            r_run_len <= (run_cycles == 32'd0) ? 32'd1 : run_cycles;
        end else if (r_state == S_SETTLE) begin
            r_cnt <= (r_cnt == 32'd0) ? (r_run_len - 32'd1) : (r_cnt - 32'd1);
        end else if (r_state == S_RUN && r_cnt != 32'd0) begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    r_result <= '0;
        else if (r_state == S_CAPTURE) r_result <= core_phase;
    end

    assign core_rstn     = w_core_rstn;
    assign core_axi_rstn = r_axi_rstn;
    assign core_wready   = r_core_wready;
    assign core_wr_addr  = r_core_wr_addr;
    assign core_wdata    = r_core_wdata;
    assign result        = r_result;
    assign done          = w_done;
    assign busy          = w_busy;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Scoreboard bench for ising_run_ctrl: expected writes and captured phases are queued at stimulus time.
module tb_ising_run_ctrl;
    localparam int N = 3;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         w_valid = 1'b0;
    logic         w_ready;
    logic [31:0]  w_addr = '0;
    logic [31:0]  w_data = '0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [31:0]  run_cycles = '0;
    logic         abort = 1'b0;
    logic         core_rstn;
    logic         core_axi_rstn;
    logic         core_wready;
    logic [31:0]  core_wr_addr;
    logic [31:0]  core_wdata;
    logic [N-1:0] core_phase = '0;
    logic [N-1:0] result;
    logic         done;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [63:0]  wq[$];
    logic [N-1:0] rq[$];
    logic [N-1:0] last_result = '0;

    ising_run_ctrl #(.N(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rstn(rstn),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
        .start_valid(start_valid), .start_ready(start_ready), .run_cycles(run_cycles),
        .abort(abort), .core_rstn(core_rstn), .core_axi_rstn(core_axi_rstn),
        .core_wready(core_wready), .core_wr_addr(core_wr_addr), .core_wdata(core_wdata),
        .core_phase(core_phase), .result(result), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every core write strobe and every done pulse consumes one queued expectation
    always @(negedge clk) begin : monitor
        logic [63:0]  ew;
        logic [N-1:0] er;
        if (core_wready === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL core_write_unexpected: got %h/%h, required no write", core_wr_addr, core_wdata);
            end else begin
                ew = wq.pop_front();
                if ({core_wr_addr, core_wdata} !== ew) begin
                    errors++;
                    $display("FAIL core_write_data: got %h/%h, required %h/%h",
                             core_wr_addr, core_wdata, ew[63:32], ew[31:0]);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done=1 result=%0d, required no done", result);
            end else begin
                er = rq.pop_front();
                last_result = er;
                if (result !== er) begin
                    errors++;
                    $display("FAIL result: got %0d, required %0d", result, er);
                end
            end
        end
    end

    task automatic test_reset();
        rstn = 1'b0; w_valid = 1'b1; start_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({core_rstn, core_axi_rstn, core_wready, done, busy, w_ready, start_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl_outputs: got %b, required 0000000",
                     {core_rstn, core_axi_rstn, core_wready, done, busy, w_ready, start_ready});
        end
        checks++;
        if ({core_wr_addr, core_wdata, result} !== '0) begin
            errors++;
            $display("FAIL reset_data_outputs: got %h/%h/%0d, required 0/0/0", core_wr_addr, core_wdata, result);
        end
        w_valid = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (core_axi_rstn !== 1'b0) begin
            errors++;
            $display("FAIL axi_rstn_before_edge: got %b, required 0", core_axi_rstn);
        end
        @(negedge clk);
        checks++;
        if (core_axi_rstn !== 1'b1) begin
            errors++;
            $display("FAIL axi_rstn_after_edge: got %b, required 1", core_axi_rstn);
        end
        checks++;
        if ({start_ready, w_ready, core_rstn, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, required 1100", {start_ready, w_ready, core_rstn, busy});
        end
    endtask

    task automatic test_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        w_valid = 1'b1; w_addr = a; w_data = d;
        @(negedge clk);
        checks++;
        if ({w_ready, start_ready} !== 2'b10) begin
            errors++;
            $display("FAIL write_ready: got w_ready/start_ready=%b, required 10", {w_ready, start_ready});
        end
        wq.push_back({a, d});
        @(posedge clk); #1;
        w_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_wready, start_ready} !== 2'b10 || core_wr_addr !== a || core_wdata !== d) begin
            errors++;
            $display("FAIL write_strobe: got wready/start_ready=%b %h/%h, required 10 %h/%h",
                     {core_wready, start_ready}, core_wr_addr, core_wdata, a, d);
        end
        @(negedge clk);
        checks++;
        if ({core_wready, start_ready} !== 2'b01 || core_wr_addr !== a || core_wdata !== d) begin
            errors++;
            $display("FAIL write_hold: got wready/start_ready=%b %h/%h, required 01 %h/%h",
                     {core_wready, start_ready}, core_wr_addr, core_wdata, a, d);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            w_valid = 1'b1; w_addr = 32'h40 + k; w_data = 32'hB00 + k;
            @(negedge clk);
            checks++;
            if (w_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b, required 1", k, w_ready);
            end
            wq.push_back({32'h40 + k, 32'hB00 + k});
        end
        @(posedge clk); #1;
        w_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (core_wready !== 1'b1 || core_wr_addr !== 32'h41) begin
            errors++;
            $display("FAIL b2b_second_strobe: got %b %h, required 1 00000041", core_wready, core_wr_addr);
        end
        @(negedge clk);
        checks++;
        if (core_wready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_strobe_end: got %b, required 0", core_wready);
        end
    endtask

    task automatic test_run(input logic [31:0] rc, input int abort_at);
        int r, cap, dcyc, last_cyc, wait_n;
        int rh_run, rh_other, first_hi, busy_n, done_n, done_at, axi_lo, wr_hi;
        int exp_rh_run, exp_busy;
        logic aborted;
        logic [N-1:0] prev;
        r = (rc == 0) ? 1 : int'(rc);
        cap = S + r + 1;
        dcyc = S + r + 2;
        aborted = (abort_at >= 1) && (abort_at <= S + r);
        prev = last_result;
        rh_run = 0; rh_other = 0; first_hi = 0; busy_n = 0;
        done_n = 0; done_at = 0; axi_lo = 0; wr_hi = 0;
        @(posedge clk); #1;
        start_valid = 1'b1; run_cycles = rc;
        wait_n = 0;
        @(negedge clk);
        while (start_ready !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout: got start_ready=%b, required 1 within 20 cycles", start_ready);
            start_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        run_cycles = '1;
        last_cyc = aborted ? abort_at + 4 : dcyc + 2;
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            core_phase = N'(cyc * 3 + 1);
            if (!aborted && cyc == cap) rq.push_back(core_phase);
            abort = (cyc == abort_at);
            @(negedge clk);
            if (core_rstn === 1'b1) begin
                if (cyc >= S + 1 && cyc <= S + r) rh_run++;
                else rh_other++;
                if (first_hi == 0) first_hi = cyc;
            end
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                if (done_at == 0) done_at = cyc;
            end
            if (core_axi_rstn !== 1'b1) axi_lo++;
            if (w_ready === 1'b1 && cyc <= (aborted ? abort_at : dcyc)) wr_hi++;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        exp_rh_run = aborted ? ((abort_at > S) ? abort_at - S : 0) : r;
        exp_busy = aborted ? abort_at : S + r + 1;
        checks++;
        if (done_n !== (aborted ? 0 : 1)) begin
            errors++;
            $display("FAIL done_count rc=%0d: got %0d, required %0d", rc, done_n, aborted ? 0 : 1);
        end
        if (!aborted) begin
            checks++;
            if (done_at !== dcyc) begin
                errors++;
                $display("FAIL done_latency rc=%0d: got %0d, required %0d", rc, done_at, dcyc);
            end
        end
        checks++;
        if (rh_run !== exp_rh_run) begin
            errors++;
            $display("FAIL rstn_run_cycles rc=%0d: got %0d, required %0d", rc, rh_run, exp_rh_run);
        end
        checks++;
        if (rh_other !== (aborted ? 0 : 1)) begin
            errors++;
            $display("FAIL rstn_outside_run rc=%0d: got %0d, required %0d", rc, rh_other, aborted ? 0 : 1);
        end
        if (exp_rh_run > 0) begin
            checks++;
            if (first_hi !== S + 1) begin
                errors++;
                $display("FAIL settle_length rc=%0d: got first high %0d, required %0d", rc, first_hi, S + 1);
            end
        end
        checks++;
        if (busy_n !== exp_busy) begin
            errors++;
            $display("FAIL busy_cycles rc=%0d: got %0d, required %0d", rc, busy_n, exp_busy);
        end
        checks++;
        if (axi_lo !== 0) begin
            errors++;
            $display("FAIL axi_rstn_run: got %0d low cycles, required 0", axi_lo);
        end
`ifndef ISING_CTRL_WFIFO_EN
        checks++;
        if (wr_hi !== 0) begin
            errors++;
            $display("FAIL w_ready_not_idle: got %0d high cycles, required 0", wr_hi);
        end
`endif
        if (aborted) begin
            checks++;
            if (result !== prev) begin
                errors++;
                $display("FAIL abort_result: got %0d, required %0d", result, prev);
            end
        end
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_idle: got start_ready=%b, required 1", start_ready);
        end
    endtask

    task automatic test_collision();
        @(posedge clk); #1;
        w_valid = 1'b1; w_addr = 32'h20; w_data = 32'hA;
        start_valid = 1'b1; run_cycles = 32'd3;
        @(negedge clk);
        checks++;
        if ({w_ready, start_ready} !== 2'b10) begin
            errors++;
            $display("FAIL collision_ready: got w_ready/start_ready=%b, required 10", {w_ready, start_ready});
        end
        wq.push_back({32'h20, 32'hA});
        @(posedge clk); #1;
        w_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({start_ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL collision_start_held: got start_ready/busy=%b, required 00", {start_ready, busy});
        end
        test_run(32'd3, 0);
    endtask

`ifdef ISING_CTRL_WFIFO_EN
    task automatic test_fifo_backpressure();
        int early, wait_n;
        core_phase = N'(5);
        @(posedge clk); #1;
        start_valid = 1'b1; run_cycles = 32'd12;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_start_ready: got %b, required 1", start_ready);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        rq.push_back(N'(5));
        repeat (S + 1) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            w_valid = 1'b1; w_addr = 32'h100 + k; w_data = 32'hA0 + k;
            @(negedge clk);
            checks++;
            if (w_ready !== (k < 4)) begin
                errors++;
                $display("FAIL fifo_ready%0d: got %b, required %b", k, w_ready, k < 4);
            end
            if (w_ready === 1'b1) wq.push_back({32'h100 + k, 32'hA0 + k});
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        early = 0;
        wait_n = 0;
        while (wq.size() != 0 && wait_n < 60) begin
            @(negedge clk);
            if (core_wready === 1'b1 && (busy === 1'b1 || done === 1'b1)) early++;
            wait_n++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL fifo_drain_during_run: got %0d strobes, required 0", early);
        end
        checks++;
        if (wq.size() !== 0) begin
            errors++;
            $display("FAIL fifo_drain_timeout: got %0d pending, required 0", wq.size());
        end
        repeat (2) @(negedge clk);
    endtask
`endif

    task automatic test_reset_midrun();
        @(posedge clk); #1;
        start_valid = 1'b1; run_cycles = 32'd6;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_start_ready: got %b, required 1", start_ready);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (S + 2) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, core_rstn, core_axi_rstn, done} !== 4'b0) begin
            errors++;
            $display("FAIL midrun_reset: got busy/rstn/axi/done=%b, required 0000",
                     {busy, core_rstn, core_axi_rstn, done});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        w_valid = 1'b1; w_addr = 32'h77; w_data = 32'h99;
        @(posedge clk); #1;
        w_valid = 1'b0;
        checks++;
        if (core_wready !== 1'b1) begin
            errors++;
            $display("FAIL midwrite_strobe: got %b, required 1", core_wready);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({core_wready, core_wr_addr, core_wdata} !== 65'b0) begin
            errors++;
            $display("FAIL midwrite_discard: got %b %h/%h, required 0 0/0", core_wready, core_wr_addr, core_wdata);
        end
        last_result = '0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({core_wready, start_ready} !== 2'b01) begin
            errors++;
            $display("FAIL after_midwrite_reset: got wready/start_ready=%b, required 01", {core_wready, start_ready});
        end
    endtask

    initial begin
        test_reset();
        test_write(32'h10, 32'h5);
        test_back_to_back();
        test_run(32'd8, 0);
        test_run(32'd0, 0);
        test_run(32'd10, S + 3);
        test_run(32'd5, 2);
        test_run(32'd2, S + 3);
        test_run(32'd2, S + 4);
        test_collision();
`ifdef ISING_CTRL_WFIFO_EN
        test_fifo_backpressure();
`endif
        test_reset_midrun();
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d writes/%0d results, required 0/0", wq.size(), rq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
